useq_ctrl: RTL

- Microprogram sequencer and access arbiter for the uprogram ROM.
- Each cycle it chooses the next microaddress from next-address control fields decoded from the current microword: increment, jump, conditional branch, call/return with a small stack, opcode dispatch, or halt.
- It also gives a host loader exclusive write access to the ROM so the uprogram can be replaced at run time.
- It sits between the microinstruction decoder and the ROM, and is the only driver of the ROM's address, write-enable and write-data pins.

---
 rtl/upgm_pkg.sv | 8 +
 rtl/useq_ctrl_pkg.sv | 26 ++
 rtl/useq_ctrl_stack.sv | 48 ++++
 rtl/useq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/upgm_pkg.sv
// upgm_pkg: microprogram ROM geometry shared by the sequencer, the decoder
// and the host loader.
//   uaddr_t : one microaddress (selects one ROM word)
//   upgm_t  : one microword as stored in the ROM
package upgm_pkg;
  typedef logic [9:0]  uaddr_t;
  typedef logic [31:0] upgm_t;
endpackage

// File: rtl/useq_ctrl_pkg.sv
// useq_types: encodings used by the microprogram sequencer.
//   seq_op_t         : next-address op field decoded from the microword
//   state_t          : sequencer / ROM-ownership state
//   USEQ_STACK_DEPTH : default return-stack depth
package useq_types;
  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_BRT      = 3'd2,
    OP_BRF      = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5,
    OP_DISPATCH = 3'd6,
    OP_HALT     = 3'd7
  } seq_op_t;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_RUN     = 3'd1,
    S_HALT    = 3'd2,
    S_LOAD    = 3'd3,
    S_RESTART = 3'd4
  } state_t;

  localparam int USEQ_STACK_DEPTH = 4;
endpackage

// File: rtl/useq_ctrl_stack.sv
// useq_stack: return-address LIFO for microprogram CALL/RET.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   clr        : synchronous empty, wins over push/pop
//   push, din  : push din when not full
//   pop        : drop the top entry when not empty
//   full/empty : occupancy flags from the registered pointer
//   top        : most recently pushed entry (don't care when empty)
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           sp;
  logic [IW-1:0]           wr_idx, rd_idx;

  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - PW'(1));
  assign full   = (sp == PW'(DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      mem <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end
endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer and uprogram-ROM access arbiter.
// Sole driver of the ROM address / write-enable / write-data pins.
//   clk, rst_n            : clock (ROM reads/writes on negedge), async reset
//   stall                 : hold the current microaddress
//   seq_op/cond/target    : next-address control decoded from the microword
//   dispatch_addr         : opcode-mapped entry point
//   load_req/valid/addr/wdata : host loader port, load_gnt = loader owns ROM
//   upgm_addr/we/wdata    : ROM pins
//   uinstr_valid          : ROM word at this posedge belongs to the sequence
//   halted, fault         : in HALT; sticky stack overflow/underflow
module useq_ctrl
  import upgm_pkg::*;
  import useq_types::*;
#(
  parameter int UADDR_W     = $bits(uaddr_t),
  parameter int UPGM_W      = $bits(upgm_t),
  parameter int STACK_DEPTH = USEQ_STACK_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [2:0]         seq_op,
  input  logic               seq_cond,
  input  logic [UADDR_W-1:0] seq_target,
  input  logic [UADDR_W-1:0] dispatch_addr,
  input  logic               load_req,
  input  logic               load_valid,
  input  logic [UADDR_W-1:0] load_addr,
  input  logic [UPGM_W-1:0]  load_wdata,
  output logic               load_gnt,
  output logic [UADDR_W-1:0] upgm_addr,
  output logic               upgm_we,
  output logic [UPGM_W-1:0]  upgm_wdata,
  output logic               uinstr_valid,
  output logic               halted,
  output logic               fault
);
  // State codes come from the package enum so the encoding lives in one place.
  localparam logic [2:0] ST_START   = S_START;
  localparam logic [2:0] ST_RUN     = S_RUN;
  localparam logic [2:0] ST_HALT    = S_HALT;
  localparam logic [2:0] ST_LOAD    = S_LOAD;
  localparam logic [2:0] ST_RESTART = S_RESTART;

  logic [2:0]         state, state_d;
  logic [UADDR_W-1:0] addr, addr_d, addr_inc, stk_top;
  logic               fault_d, push, pop, clr, stk_full, stk_empty;

  assign addr_inc = addr + UADDR_W'(1);

  useq_stack #(.DEPTH(STACK_DEPTH), .W(UADDR_W)) u_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (push),
    .pop  (pop),
    .din  (addr_inc),
    .full (stk_full),
    .empty(stk_empty),
    .top  (stk_top)
  );

  always_comb begin
    state_d = state;
    addr_d  = addr;
    fault_d = fault;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_START: state_d = load_req ? ST_LOAD : ST_RUN;
      ST_RUN: begin
        // Loader wins over both stall and the in-flight op.
        if (load_req) begin
          state_d = ST_LOAD;
        end else if (!stall) begin
          case (seq_op_t'(seq_op))
            OP_NEXT:     addr_d = addr_inc;
            OP_JUMP:     addr_d = seq_target;
            OP_BRT:      addr_d = seq_cond ? seq_target : addr_inc;
            OP_BRF:      addr_d = seq_cond ? addr_inc : seq_target;
            OP_CALL: begin
              if (stk_full) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
              end else begin
                push   = 1'b1;
                addr_d = seq_target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
              end else begin
                pop    = 1'b1;
                addr_d = stk_top;
              end
            end
            OP_DISPATCH: addr_d  = dispatch_addr;
            default:     state_d = ST_HALT;
          endcase
        end
      end
      ST_HALT: if (load_req) state_d = ST_LOAD;
      ST_LOAD: begin
        // Zero the address and stack on the way out so RESTART fetches word 0.
        if (!load_req) begin
          state_d = ST_RESTART;
          addr_d  = '0;
          clr     = 1'b1;
        end
      end
      ST_RESTART: state_d = ST_RUN;
      default:    state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_START;
      addr  <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      fault <= fault_d;
    end
  end

  // Loader-side pins decode straight from the state register, so an async
  // reset drops write-enable and grant without waiting for a clock.
  assign load_gnt     = (state == ST_LOAD);
  assign upgm_addr    = load_gnt ? load_addr : addr;
  assign upgm_we      = load_gnt & load_valid;
  assign upgm_wdata   = load_gnt ? load_wdata : '0;
  assign uinstr_valid = (state == ST_RUN);
  assign halted       = (state == ST_HALT);
endmodule
